agp32_mem_responder: RTL and testbench

- Memory-side responder for the agp32 processor's command/ready memory interface.
- Owns a word-organised RAM and serves instruction fetches, data reads, byte/word writes and interrupt fences. Reports completion on `ready` and faults on `error`.
- Drives the power-up `mem_start_ready` handshake and answers the processor's `interrupt_req` with `interrupt_ack`.
- Sits beside agp32_processor at top level, wired port-to-port.

---
 rtl/agp32_mem_pkg.sv | 52 +++++
 rtl/agp32_mem_ram.sv | 65 ++++++
 rtl/agp32_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_agp32_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/agp32_mem_pkg.sv
// Shared types and helpers for the agp32 memory responder.
package agp32_mem_pkg;

  // Command encodings driven by the processor on `command`.
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    IRQ   = 3'd4
  } mem_cmd_t;

  // Fault codes reported on `error`.
  typedef enum logic [1:0] {
    OK       = 2'd0,
    RANGE    = 2'd1,
    MISALIGN = 2'd2,
    ILLEGAL  = 2'd3
  } mem_err_t;

  // Command FSM states.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_ERR  = 2'd3
  } mem_state_t;

  // Instruction word presented before the first fetch completes.
  localparam logic [31:0] NOP_INSTR = 32'd63;

  // Classify a command at latch time. Priority: illegal, then range, then alignment.
  // Byte-strobe writes may target any byte address; only full-word writes must be aligned.
  function automatic mem_err_t check_cmd(input logic [2:0]  cmd,
                                         input logic [31:0] addr,
                                         input logic [3:0]  wstrb,
                                         input logic [32:0] limit);
    mem_err_t res;
    res = OK;
    if (cmd > 3'(IRQ)) begin
      res = ILLEGAL;
    end else if (cmd == 3'(FETCH) || cmd == 3'(READ) || cmd == 3'(WRITE)) begin
      if ({1'b0, addr} >= limit) begin
        res = RANGE;
      end else if ((cmd != 3'(WRITE) || wstrb == 4'hF) && addr[1:0] != 2'b00) begin
        res = MISALIGN;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/agp32_mem_ram.sv
// Word-organised RAM with per-byte write enables, registered read and a backdoor write port.
module agp32_mem_ram #(
  parameter int    MEM_WORDS = 4096,
  parameter string INIT_FILE = "",
  parameter int    AW        = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [3:0]    wr_strb_i,
  input  logic          bd_we_i,
  input  logic [31:0]   bd_addr_i,
  input  logic [31:0]   bd_wdata_i
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   rd_data_q;
  logic          bd_ok;
  logic          we_d;
  logic [AW-1:0] waddr_d;
  logic [31:0]   wdata_d;
  logic [3:0]    wstrb_d;

  // RAM starts as all zeros.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = 32'd0;
    end
  end

  // Core writes win the single write port; backdoor is a full-word write, dropped when out of range.
  always_comb begin
    bd_ok   = bd_we_i && ({1'b0, bd_addr_i} < ADDR_LIMIT);
    we_d    = 1'b0;
    waddr_d = wr_addr_i;
    wdata_d = wr_data_i;
    wstrb_d = wr_strb_i;
    if (wr_en_i) begin
      we_d = 1'b1;
    end else if (bd_ok) begin
      we_d    = 1'b1;
      waddr_d = bd_addr_i[AW+1:2];
      wdata_d = bd_wdata_i;
      wstrb_d = 4'hF;
    end
  end

  // Byte-lane write and registered read (read returns the pre-write word on a same-edge collision).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_d && wstrb_d[i]) begin
        mem[waddr_d][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/agp32_mem_responder.sv
// Memory-side responder for the agp32 command/ready interface: init handshake,
// fetch/read/write/fence servicing with fixed latency, fault reporting and interrupt ack.
module agp32_mem_responder
  import agp32_mem_pkg::*;
#(
  parameter int    MEM_WORDS     = 4096,
  parameter int    LATENCY       = 2,
  parameter int    INIT_CYCLES   = 8,
  parameter int    IRQ_ACK_DELAY = 3,
  parameter string INIT_FILE     = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] inst_addr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic        interrupt_req,
  output logic        ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        mem_start_ready,
  output logic [1:0]  error,
  output logic        interrupt_ack,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata
);

  localparam int          AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);
  localparam int          LAT_CW     = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int          INIT_CW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int          IRQ_CW     = (IRQ_ACK_DELAY > 1) ? $clog2(IRQ_ACK_DELAY + 1) : 1;
  localparam logic [LAT_CW-1:0]  LAT_LOAD  = LAT_CW'(LATENCY - 1);
  localparam logic [INIT_CW-1:0] INIT_LAST = INIT_CW'(INIT_CYCLES - 1);
  localparam logic [IRQ_CW-1:0]  IRQ_LIM   = IRQ_CW'(IRQ_ACK_DELAY);

  mem_state_t         state_q;
  mem_cmd_t           cmd_q;
  logic [AW-1:0]      addr_idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic [LAT_CW-1:0]  lat_cnt_q;
  logic [INIT_CW-1:0] init_cnt_q;
  logic               ready_q;
  logic               start_ready_q;
  mem_err_t           error_q;
  logic [31:0]        inst_rdata_q;
  logic [31:0]        data_rdata_q;
  logic [IRQ_CW-1:0]  irq_cnt_q;
  logic [IRQ_CW-1:0]  irq_cnt_d;
  logic               irq_ack_q;

  logic [31:0]        chk_addr_d;
  mem_err_t           lat_err_d;
  logic [AW-1:0]      rd_idx_d;
  logic               done_d;
  logic               ram_we_d;
  logic               bd_allow_d;
  logic [31:0]        ram_rdata;

  // Command decode: the address a command is checked against, its fault class, and the RAM controls.
  // In IDLE the RAM is pointed at the incoming address so LATENCY=1 still sees the right word.
  always_comb begin
    chk_addr_d = (command == 3'(FETCH)) ? inst_addr : data_addr;
    lat_err_d  = check_cmd(command, chk_addr_d, data_wstrb, ADDR_LIMIT);
    rd_idx_d   = (state_q == ST_IDLE) ? chk_addr_d[AW+1:2] : addr_idx_q;
    done_d     = (state_q == ST_BUSY) && (lat_cnt_q == '0);
    ram_we_d   = done_d && (cmd_q == WRITE);
    bd_allow_d = bd_we && ((state_q == ST_INIT) ||
                           ((state_q == ST_IDLE) && (command == 3'(NONE))));
  end

  agp32_mem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE),
    .AW        (AW)
  ) u_ram (
    .clk        (clk),
    .rd_addr_i  (rd_idx_d),
    .rd_data_o  (ram_rdata),
    .wr_en_i    (ram_we_d),
    .wr_addr_i  (addr_idx_q),
    .wr_data_i  (wdata_q),
    .wr_strb_i  (wstrb_q),
    .bd_we_i    (bd_allow_d),
    .bd_addr_i  (bd_addr),
    .bd_wdata_i (bd_wdata)
  );

  // Command FSM with registered outputs; ERR is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cmd_q         <= NONE;
      addr_idx_q    <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      lat_cnt_q     <= '0;
      init_cnt_q    <= '0;
      ready_q       <= 1'b0;
      start_ready_q <= 1'b0;
      error_q       <= OK;
      inst_rdata_q  <= NOP_INSTR;
      data_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            start_ready_q <= 1'b1;
            ready_q       <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            init_cnt_q <= init_cnt_q + INIT_CW'(1);
          end
        end
        ST_IDLE: begin
          if (command != 3'(NONE)) begin
            cmd_q      <= mem_cmd_t'(command);
            addr_idx_q <= chk_addr_d[AW+1:2];
            wdata_q    <= data_wdata;
            wstrb_q    <= data_wstrb;
            ready_q    <= 1'b0;
            if (lat_err_d != OK) begin
              error_q <= lat_err_d;
              state_q <= ST_ERR;
            end else begin
              lat_cnt_q <= LAT_LOAD;
              state_q   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (lat_cnt_q == '0) begin
            if (cmd_q == FETCH) begin
              inst_rdata_q <= ram_rdata;
            end
            if (cmd_q == READ) begin
              data_rdata_q <= ram_rdata;
            end
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_CW'(1);
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  // Saturating interrupt counter; ack rises when the request has been seen IRQ_ACK_DELAY edges.
  always_comb begin
    irq_cnt_d = (irq_cnt_q == IRQ_LIM) ? irq_cnt_q : irq_cnt_q + IRQ_CW'(1);
  end

  // Interrupt acknowledge, independent of the command FSM; drops on the first edge without request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_cnt_q <= '0;
      irq_ack_q <= 1'b0;
    end else if (interrupt_req) begin
      irq_cnt_q <= irq_cnt_d;
      irq_ack_q <= (irq_cnt_d >= IRQ_LIM);
    end else begin
      irq_cnt_q <= '0;
      irq_ack_q <= 1'b0;
    end
  end

  assign ready           = ready_q;
  assign inst_rdata      = inst_rdata_q;
  assign data_rdata      = data_rdata_q;
  assign mem_start_ready = start_ready_q;
  assign error           = error_q;
  assign interrupt_ack   = irq_ack_q;

endmodule

// File: tb/tb_agp32_mem_responder.sv
// Directed bench for agp32_mem_responder with hand-computed expectations.
module tb_agp32_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  command = 3'd0;
  logic [31:0] inst_addr = 32'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [3:0]  data_wstrb = 4'd0;
  logic        interrupt_req = 1'b0;
  logic        ready;
  logic [31:0] inst_rdata;
  logic [31:0] data_rdata;
  logic        mem_start_ready;
  logic [1:0]  error;
  logic        interrupt_ack;
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = 32'd0;
  logic [31:0] bd_wdata = 32'd0;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  agp32_mem_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .command         (command),
    .inst_addr       (inst_addr),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_wstrb      (data_wstrb),
    .interrupt_req   (interrupt_req),
    .ready           (ready),
    .inst_rdata      (inst_rdata),
    .data_rdata      (data_rdata),
    .mem_start_ready (mem_start_ready),
    .error           (error),
    .interrupt_ack   (interrupt_ack),
    .bd_we           (bd_we),
    .bd_addr         (bd_addr),
    .bd_wdata        (bd_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, obs);
    end
  endtask

  // All tasks are entered at a negedge and return at a negedge.
  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    command = c; inst_addr = a; data_addr = a; data_wdata = wd; data_wstrb = ws;
    @(negedge clk);
    command = 3'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!mem_start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", {31'd0, mem_start_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_msr", {31'd0, mem_start_ready}, 32'd0);
    chk("rst_error", {30'd0, error}, 32'd0);
    chk("rst_ack", {31'd0, interrupt_ack}, 32'd0);
    chk("rst_drdata", data_rdata, 32'd0);
    chk("rst_irdata", inst_rdata, 32'd63);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("init_msr_%0d", k), {31'd0, mem_start_ready}, (k == 8) ? 32'd1 : 32'd0);
    end
    chk("init_ready", {31'd0, ready}, 32'd1);
    chk("init_irdata", inst_rdata, 32'd63);

    // Preload through the backdoor
    bd_write(32'd20, 32'hDEADBEEF);
    bd_write(32'h40, 32'h11223344);
    bd_write(32'h80, 32'hCAFEF00D);
    bd_write(32'd16380, 32'h0BADC0DE);
    bd_write(32'd16384, 32'hFFFFFFFF);

    // Fetch
    issue(3'd1, 32'd20, 32'd0, 4'd0);
    chk("fetch_busy", {31'd0, ready}, 32'd0);
    wait_done(lat);
    chk("fetch_lat", lat, 32'd2);
    chk("fetch_data", inst_rdata, 32'hDEADBEEF);

    // Byte write then read-after-write
    issue(3'd3, 32'h40, 32'h00AB0000, 4'b0100);
    wait_done(lat);
    chk("wr_lat", lat, 32'd2);
    issue(3'd2, 32'h40, 32'd0, 4'd0);
    wait_done(lat);
    chk("raw_data", data_rdata, 32'h11AB3344);

    // Byte strobe on an unaligned address is legal
    issue(3'd3, 32'h43, 32'hFF000000, 4'b1000);
    wait_done(lat);
    chk("unal_byte_err", {30'd0, error}, 32'd0);
    issue(3'd2, 32'h40, 32'd0, 4'd0);
    wait_done(lat);
    chk("unal_byte_data", data_rdata, 32'hFFAB3344);

    // Full word write / read
    issue(3'd3, 32'h44, 32'h55667788, 4'hF);
    wait_done(lat);
    issue(3'd2, 32'h44, 32'd0, 4'd0);
    wait_done(lat);
    chk("word_data", data_rdata, 32'h55667788);

    // Last word in range
    issue(3'd2, 32'd16380, 32'd0, 4'd0);
    wait_done(lat);
    chk("top_word", data_rdata, 32'h0BADC0DE);

    // Interrupt handshake
    interrupt_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("irq_ack_%0d", k), {31'd0, interrupt_ack}, (k >= 3) ? 32'd1 : 32'd0);
    end
    interrupt_req = 1'b0;
    @(negedge clk);
    chk("irq_ack_drop", {31'd0, interrupt_ack}, 32'd0);

    // Fence leaves RAM untouched
    issue(3'd4, 32'h40, 32'h0, 4'hF);
    wait_done(lat);
    chk("fence_lat", lat, 32'd2);
    issue(3'd2, 32'h40, 32'd0, 4'd0);
    wait_done(lat);
    chk("fence_ram", data_rdata, 32'hFFAB3344);

    // Reset in the middle of a write
    issue(3'd3, 32'h80, 32'h00000000, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd0);
    chk("arst_msr", {31'd0, mem_start_ready}, 32'd0);
    chk("arst_irdata", inst_rdata, 32'd63);
    chk("arst_drdata", data_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    issue(3'd2, 32'h80, 32'd0, 4'd0);
    wait_done(lat);
    chk("arst_nowrite", data_rdata, 32'hCAFEF00D);

    // Faults (sticky)
    issue(3'd2, 32'h42, 32'd0, 4'd0);
    chk("mis_err", {30'd0, error}, 32'd2);
    repeat (10) @(negedge clk);
    chk("mis_ready", {31'd0, ready}, 32'd0);
    chk("mis_sticky", {30'd0, error}, 32'd2);
    do_reset();
    chk("err_clear", {30'd0, error}, 32'd0);
    issue(3'd2, 32'd16384, 32'd0, 4'd0);
    chk("rng_err", {30'd0, error}, 32'd1);
    do_reset();
    issue(3'd6, 32'd0, 32'd0, 4'd0);
    chk("ill_err", {30'd0, error}, 32'd3);
    repeat (4) @(negedge clk);
    chk("ill_ready", {31'd0, ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
